memory_arbiter: RTL
===================

# memory_arbiter

Sequences the single shared memory port between the instruction-fetch requester and the data load/store requester of the pipelined CPU. Accepts one request at a time, drives the memory for a fixed latency, and returns read data (or a write completion) to the owning requester. Grants act as stall releases for the fetch and memory stages. The block sits between the Fetch/Memory pipeline stages and `mem`, which becomes single-ported behind it.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MEM_LATENCY`, 1, cycles from the first address cycle to valid `mem_rdata`; must be ≥1
- `STARVE_LIMIT`, 4, consecutive data grants tolerated while fetch waits
- `clock` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low reset
- `ifetch_req` in 1: fetch request; held with its address until granted
- `ifetch_addr` in ADDR_W: fetch address (PC)
- `ifetch_gnt` out 1: request accepted this cycle
- `ifetch_rvalid` out 1: one-cycle pulse carrying fetched instruction
- `ifetch_rdata` out DATA_W: instruction word
- `data_req` in 1: data request; held with its payload until granted
- `data_we` in 1: 1 = store, 0 = load
- `data_addr` in ADDR_W: data address
- `data_wdata` in DATA_W: store data
- `data_gnt` out 1: data request accepted this cycle
- `data_rvalid` out 1: one-cycle completion pulse (load data or store ack)
- `data_rdata` out DATA_W: load data; 0 on store completion
- `mem_addr` out ADDR_W: memory address
- `mem_we` out 1: memory write enable
- `mem_wdata` out DATA_W: memory write data
- `mem_rdata` in DATA_W: memory read data
- `busy` out 1: access in flight

## Operation
- States: IDLE, ACCESS.
- IDLE: if any request is present, pick a winner, assert its `*_gnt` combinationally in the same cycle, latch addr/we/wdata/source, load the latency counter with `MEM_LATENCY`, and go to ACCESS. Otherwise stay in IDLE.
- Priority: data beats fetch, because data belongs to the older instruction. The starvation guard can override this (see Configuration).
- ACCESS:
  - `mem_addr` and `mem_wdata` come from the latched registers.
  - `mem_we` is high only in the first ACCESS cycle, and only for stores.
  - The counter decrements each cycle. When it reaches 1, `mem_rdata` is captured into the owner's rdata register at that edge and the state returns to IDLE.
- Completion:
  - The owner's `*_rvalid` is high for exactly the first IDLE cycle after ACCESS.
  - The rdata registers hold their value until the next completion to the same source.
  - A new grant may occur in that same completion cycle.
- Outside ACCESS, `mem_addr`, `mem_wdata` and `mem_we` are 0.
- A requester may drop its `req` before it is granted; nothing is issued. After a grant, the in-flight access cannot be cancelled.
- `busy` = (state == ACCESS).

## Timing
- Reset (asynchronous, `reset`=0):
  - State goes to IDLE, counter to 0, starvation count to 0.
  - All outputs are 0, including rdata registers; `mem_we` is 0 immediately.
  - An access in flight mid-reset is dropped and no `rvalid` is generated.
- Grant in cycle T:
  - Memory is driven in cycles T+1 … T+MEM_LATENCY.
  - Capture happens at the end of cycle T+MEM_LATENCY.
  - `rvalid` is high in cycle T+MEM_LATENCY+1.
- Back-to-back throughput: one access per MEM_LATENCY+1 cycles.
- While ACCESS is active, both `*_gnt` stay 0 regardless of requests.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined:
  - A counter increments on each data grant made while `ifetch_req`=1.
  - It clears on a fetch grant, or on any IDLE cycle with `ifetch_req`=0.
  - When the count equals `STARVE_LIMIT` and both requests are present, fetch wins.
  - The counter saturates at `STARVE_LIMIT`.
- Undefined: strict data priority; no counter logic is generated.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum typedef (`ARB_IDLE`, `ARB_ACCESS`);
  - the source enum (`SRC_FETCH`, `SRC_DATA`);
  - the default width constants.
- One sub-module, `starve_counter`: a saturating counter with increment/clear inputs and an `at_limit` output. It is instantiated only under `MEM_ARB_STARVE_GUARD_EN`.

## Test plan
- **Reset:** hold `reset`=0 with both reqs high → all outputs 0, no gnt. Release → data granted first.
- **Single load:** `MEM_LATENCY`=1, `data_req` with addr 0x40, mem returns 0xDEADBEEF.
  - `data_gnt` in T, `mem_addr`=0x40 in T+1.
  - `data_rvalid` with 0xDEADBEEF in T+2; `ifetch_rvalid` stays 0.
- **Store:** `data_we`=1, addr 0x80, wdata 0x1234.
  - `mem_we`=1 for only T+1 with correct addr/data.
  - `data_rvalid` in T+2 with `data_rdata`=0.
- **Contention:** both reqs held continuously, `STARVE_LIMIT`=4.
  - With the guard: grant sequence D,D,D,D,F,D…
  - Without the guard: F is never granted.
- **Latency 3:** fetch addr 0x100 → `mem_addr` held 3 cycles, `ifetch_rvalid` at T+4, and a grant to a pending data req in that same cycle.
- **Mid-access reset:** assert `reset` in T+1 of a load → `mem_addr`/`mem_we` go to 0 asynchronously and no `rvalid` follows after release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types and default constants for memory_arbiter and its
//   starvation counter.
//   - arb_state_t : arbiter FSM state (ARB_IDLE, ARB_ACCESS)
//   - arb_src_t   : owner of the access in flight (SRC_FETCH, SRC_DATA)
//   - DEFAULT_*   : default parameter values for the arbiter
package mem_arb_pkg;

  localparam int DEFAULT_ADDR_W       = 32;
  localparam int DEFAULT_DATA_W       = 32;
  localparam int DEFAULT_MEM_LATENCY  = 1;
  localparam int DEFAULT_STARVE_LIMIT = 4;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_ACCESS = 1'b1
  } arb_state_t;

  typedef enum logic {
    SRC_FETCH = 1'b0,
    SRC_DATA  = 1'b1
  } arb_src_t;

endpackage

// File: rtl/memory_arbiter_starve_counter.sv
// starve_counter
//   Saturating counter of consecutive data grants made while fetch waits.
//   Ports:
//     i_clk      : clock, rising edge
//     i_rst_n    : asynchronous active-low reset
//     i_inc      : count one more data grant (ignored once saturated)
//     i_clr      : clear the count (wins over i_inc)
//     o_at_limit : count has reached LIMIT
module starve_counter #(
  parameter int LIMIT = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_limit
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != CW'(LIMIT))) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_at_limit = (r_count == CW'(LIMIT));

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter
//   Shares one memory port between the instruction-fetch and data
//   load/store requesters. One access at a time, fixed MEM_LATENCY.
//   Optional feature macro: MEM_ARB_STARVE_GUARD_EN (fetch starvation guard).
//   Ports:
//     clock, reset                   : clock (rising edge), async active-low reset
//     ifetch_req/addr                : fetch request, held until granted
//     ifetch_gnt                     : fetch accepted this cycle (combinational)
//     ifetch_rvalid/rdata            : one-cycle instruction return pulse / word
//     data_req/we/addr/wdata         : data request, held until granted
//     data_gnt                       : data accepted this cycle (combinational)
//     data_rvalid/rdata              : completion pulse / load data (0 for stores)
//     mem_addr/we/wdata, mem_rdata   : single memory port (zero outside ACCESS)
//     busy                           : access in flight (FSM state == ARB_ACCESS)
//   Handshake: a requester holds req with its payload stable; the cycle its
//   gnt is high the payload is latched and the access can no longer be
//   cancelled. Completion is signalled by a single rvalid pulse in the first
//   IDLE cycle after ACCESS, in which a new grant may also be given.
module memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEFAULT_ADDR_W,
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int MEM_LATENCY  = DEFAULT_MEM_LATENCY,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ifetch_req,
  input  logic [ADDR_W-1:0] ifetch_addr,
  output logic              ifetch_gnt,
  output logic              ifetch_rvalid,
  output logic [DATA_W-1:0] ifetch_rdata,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_gnt,
  output logic              data_rvalid,
  output logic [DATA_W-1:0] data_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int LW = $clog2(MEM_LATENCY + 1);

  arb_state_t        r_state;
  arb_state_t        w_next_state;
  logic [LW-1:0]     r_lat_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  arb_src_t          r_src;
  logic [DATA_W-1:0] r_ifetch_rdata;
  logic [DATA_W-1:0] r_data_rdata;
  logic              r_ifetch_rvalid;
  logic              r_data_rvalid;

  logic w_grant_fetch;
  logic w_grant_data;
  logic w_fetch_wins;
  logic w_done;
  logic w_starve_at_limit;

  // Data belongs to the older instruction, so it wins unless fetch has
  // been starved for STARVE_LIMIT grants.
  assign w_fetch_wins = ifetch_req && (!data_req || w_starve_at_limit);
  assign w_done       = (r_state == ARB_ACCESS) && (r_lat_cnt == LW'(1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ARB_IDLE;
    else        r_state <= w_next_state;
  end

  // Grants are gated with reset so nothing is accepted while it is held.
  always_comb begin
    w_next_state  = r_state;
    w_grant_fetch = 1'b0;
    w_grant_data  = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (reset && (ifetch_req || data_req)) begin
          w_next_state = ARB_ACCESS;
          if (w_fetch_wins) w_grant_fetch = 1'b1;
          else              w_grant_data  = 1'b1;
        end
      end
      ARB_ACCESS: begin
        if (w_done) w_next_state = ARB_IDLE;
      end
      default: w_next_state = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_lat_cnt       <= '0;
      r_addr          <= '0;
      r_we            <= 1'b0;
      r_wdata         <= '0;
      r_src           <= SRC_FETCH;
      r_ifetch_rdata  <= '0;
      r_data_rdata    <= '0;
      r_ifetch_rvalid <= 1'b0;
      r_data_rvalid   <= 1'b0;
    end else begin
      r_ifetch_rvalid <= 1'b0;
      r_data_rvalid   <= 1'b0;
      if (w_grant_fetch || w_grant_data) begin
        r_lat_cnt <= LW'(MEM_LATENCY);
        r_addr    <= w_grant_fetch ? ifetch_addr : data_addr;
        r_we      <= w_grant_data && data_we;
        r_wdata   <= w_grant_data ? data_wdata : '0;
        r_src     <= w_grant_fetch ? SRC_FETCH : SRC_DATA;
      end else if (r_state == ARB_ACCESS) begin
        r_lat_cnt <= r_lat_cnt - 1'b1;
        if (w_done) begin
          if (r_src == SRC_FETCH) begin
            r_ifetch_rdata  <= mem_rdata;
            r_ifetch_rvalid <= 1'b1;
          end else begin
            r_data_rdata  <= r_we ? '0 : mem_rdata;
            r_data_rvalid <= 1'b1;
          end
        end
      end
    end
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve_counter (
    .i_clk      (clock),
    .i_rst_n    (reset),
    .i_inc      (w_grant_data && ifetch_req),
    .i_clr      (w_grant_fetch || ((r_state == ARB_IDLE) && !ifetch_req)),
    .o_at_limit (w_starve_at_limit)
  );
`else
  logic w_unused_starve_limit;
  assign w_unused_starve_limit = (STARVE_LIMIT != 0);
  assign w_starve_at_limit     = 1'b0;
`endif

  assign busy          = (r_state == ARB_ACCESS);
  assign ifetch_gnt    = w_grant_fetch;
  assign data_gnt      = w_grant_data;
  assign ifetch_rvalid = r_ifetch_rvalid;
  assign ifetch_rdata  = r_ifetch_rdata;
  assign data_rvalid   = r_data_rvalid;
  assign data_rdata    = r_data_rdata;
  // Write enable only in the first ACCESS cycle, when the counter is still full.
  assign mem_addr      = busy ? r_addr : '0;
  assign mem_wdata     = busy ? r_wdata : '0;
  assign mem_we        = busy && r_we && (r_lat_cnt == LW'(MEM_LATENCY));

endmodule
